// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, sequencer state and instruction word layout
package cpu_pkg;

  localparam int OPC_W = 3;
  localparam int OPD_W = 8;

  localparam logic [OPC_W-1:0] OP_MOV  = 3'd0;
  localparam logic [OPC_W-1:0] OP_MAC  = 3'd1;
  localparam logic [OPC_W-1:0] OP_WAIT = 3'd2;
  localparam logic [OPC_W-1:0] OP_SETB = 3'd3;
  localparam logic [OPC_W-1:0] OP_SETD = 3'd4;
  localparam logic [OPC_W-1:0] OP_SETE = 3'd5;
  localparam logic [OPC_W-1:0] OP_LDSW = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_WAIT,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [OPD_W-1:0] operand;
  } instr_t;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - loadable down-counter that flags the last cycle of a WAIT stall
module wait_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             clear,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // Holds at zero rather than wrapping, so a stray decrement can never restart a stall.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/issue FSM with WAIT stall; SEQ_LOOP_EN makes passes repeat
module instruction_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_WIDTH  = 3,
  parameter int OPERAND_WIDTH = 8,
  parameter int ADDR_WIDTH    = 6,
  parameter int PROG_LEN      = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  stop,
  output logic                                  imem_en,
  output logic [ADDR_WIDTH-1:0]                 imem_addr,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] imem_rdata,
  output logic [OPCODE_WIDTH-1:0]               opcode,
  output logic [OPERAND_WIDTH-1:0]              operand,
  output logic                                  instr_valid,
  output logic [ADDR_WIDTH-1:0]                 pc,
  output logic                                  busy,
  output logic                                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(PROG_LEN - 1);

  seq_state_t                state;
  logic [OPCODE_WIDTH-1:0]   rd_opcode;
  logic [OPERAND_WIDTH-1:0]  rd_operand;
  logic                      is_stall;
  logic                      at_last;
  logic                      last_q;
  logic                      expire;
  logic                      timer_load;
  logic                      timer_clear;
`ifdef SEQ_LOOP_EN
  logic                      wrap_q;
`endif

  assign {rd_opcode, rd_operand} = imem_rdata;
  assign is_stall    = (rd_opcode == OPCODE_WIDTH'(OP_WAIT)) && (rd_operand != '0);
  assign at_last     = (pc == LAST_PC);
  assign imem_addr   = pc;
  assign timer_load  = (state == S_CAPTURE) && is_stall;
  assign timer_clear = stop && (state != S_IDLE);

  wait_timer #(.WIDTH(OPERAND_WIDTH)) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .value  (rd_operand),
    .clear  (timer_clear),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      opcode      <= '0;
      operand     <= '0;
      instr_valid <= 1'b0;
      imem_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      last_q      <= 1'b0;
`ifdef SEQ_LOOP_EN
      wrap_q      <= 1'b0;
`endif
    end else begin
      instr_valid <= 1'b0;
      imem_en     <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b1;
`ifdef SEQ_LOOP_EN
      wrap_q      <= 1'b0;
      done        <= wrap_q;
`endif
      case (state)
        S_IDLE: begin
          busy <= start && !stop;
          if (start && !stop) begin
            state   <= S_FETCH;
            pc      <= '0;
            imem_en <= 1'b1;
          end
        end
        S_FETCH: state <= S_CAPTURE;
        S_CAPTURE: begin
          opcode      <= rd_opcode;
          operand     <= rd_operand;
          instr_valid <= 1'b1;
          last_q      <= at_last;
          pc          <= pc + 1'b1;
          if (is_stall) begin
            state <= S_WAIT;
          end else if (at_last) begin
`ifdef SEQ_LOOP_EN
            state   <= S_FETCH;
            imem_en <= 1'b1;
            pc      <= '0;
            wrap_q  <= 1'b1;
`else
            state   <= S_DONE;
`endif
          end else begin
            state   <= S_FETCH;
            imem_en <= 1'b1;
          end
        end
        S_WAIT: begin
          if (expire) begin
            if (last_q) begin
`ifdef SEQ_LOOP_EN
              state   <= S_FETCH;
              imem_en <= 1'b1;
              pc      <= '0;
              wrap_q  <= 1'b1;
`else
              state   <= S_DONE;
`endif
            end else begin
              state   <= S_FETCH;
              imem_en <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      // Abort: an instruction already in CAPTURE is still issued, everything else is dropped.
      if (stop && (state != S_IDLE)) begin
        state   <= S_IDLE;
        imem_en <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b0;
`ifdef SEQ_LOOP_EN
        wrap_q  <= 1'b0;
`endif
        if (state != S_CAPTURE) begin
          instr_valid <= 1'b0;
          pc          <= pc;
        end
      end
    end
  end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Fetches instruction words from a synchronous instruction ROM, splits each into opcode and operand, and issues them one at a time to `instruction_decoder`. It sits directly upstream of the decoder and owns the program counter, program start/stop/done sequencing and the cycle stall for the WAIT opcode. A program runs from address 0 to `PROG_LEN-1`.

## Interface
Parameters:
- `OPCODE_WIDTH`, 3: opcode field width; must match the decoder.
- `OPERAND_WIDTH`, 8: operand field width; also the WAIT count width.
- `ADDR_WIDTH`, 6: program counter and ROM address width.
- `PROG_LEN`, 64: number of instructions per pass; 1 ≤ `PROG_LEN` ≤ 2**`ADDR_WIDTH`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a program pass; sampled only in IDLE.
- `stop`  in  1  synchronous abort; honoured in any state.
- `imem_en`  out  1  ROM read enable.
- `imem_addr`  out  `ADDR_WIDTH`  ROM read address (= `pc`).
- `imem_rdata`  in  `OPCODE_WIDTH+OPERAND_WIDTH`  ROM data, valid one cycle after `imem_en`; `{opcode, operand}` with opcode in the MSBs.
- `opcode`  out  `OPCODE_WIDTH`  registered opcode to the decoder.
- `operand`  out  `OPERAND_WIDTH`  registered operand.
- `instr_valid`  out  1  one-cycle pulse: `opcode`/`operand` are a new instruction.
- `pc`  out  `ADDR_WIDTH`  current program counter.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on completion of a pass.

## Operation
- States: IDLE, FETCH, CAPTURE, WAIT, DONE.
- IDLE: `start`=1 and `stop`=0 → FETCH, `pc`←0. If `start` and `stop` are both high, `stop` wins and the state stays IDLE.
- FETCH: `imem_en`=1, `imem_addr`=`pc` → CAPTURE.
- CAPTURE: `imem_rdata` is valid. On the clock edge: load `opcode`/`operand`, set `instr_valid`←1, `pc`←`pc`+1. Next state:
  - WAIT if the opcode is WAIT and the operand is nonzero; the wait counter loads the operand.
  - otherwise DONE if `pc` = `PROG_LEN-1`;
  - otherwise FETCH.
- WAIT: `imem_en`=0. The counter decrements each cycle. When the counter = 1, go to DONE if the WAIT was the last instruction, otherwise FETCH. WAIT n therefore inserts exactly n extra cycles. WAIT with operand 0 behaves like any other opcode.
- DONE: `done`=1 for one cycle → IDLE. `pc` holds its final value until the next `start`.
- `stop` in any non-IDLE state: the next state is IDLE, `instr_valid`←0, the wait counter is cleared, `done` is not pulsed and `pc` holds.
- `start` outside IDLE is ignored.
- `instr_valid` is high for exactly one cycle per issued instruction. `opcode`/`operand` hold their last value between pulses.

## Timing
- Reset: state IDLE; `pc`, `opcode`, `operand`, `instr_valid`, `imem_en`, `busy`, `done` and the wait counter are all 0.
- `start` high in cycle 0 → FETCH in cycle 1 → CAPTURE in cycle 2 → `instr_valid` high in cycle 3.
- Steady issue rate: one instruction every 2 cycles. `instr_valid` coincides with the next FETCH.
- WAIT n: the next `instr_valid` arrives n+2 cycles after the WAIT's `instr_valid`.
- `done` rises the cycle after the final `instr_valid`, or the cycle after the final WAIT expires.
- `busy` is registered from the state: it is high from the cycle after `start` through the DONE cycle.
- `stop` takes effect at the next edge. A `stop` coincident with CAPTURE still issues that instruction (`instr_valid` pulses the following cycle) and then goes to IDLE.
- `pc` increments modulo 2**`ADDR_WIDTH`. The wait counter is `OPERAND_WIDTH` wide and never underflows.

## Configuration
- `SEQ_LOOP_EN` defined: at the end of a pass, `pc` wraps to 0 and the sequencer returns to FETCH instead of DONE. `done` still pulses for one cycle at each wrap while `busy` stays high. Only `stop` (or reset) returns the block to IDLE.
- `SEQ_LOOP_EN` undefined: single pass, then IDLE as described above.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams `OP_MOV`, `OP_MAC`, `OP_WAIT`, `OP_SETB`, `OP_SETD`, `OP_SETE`, `OP_LDSW`, with values identical to the opcode macros used by the decoder;
  - the `seq_state_t` enum;
  - the packed `instr_t` struct (`opcode`, `operand`).
- One sub-module, `wait_timer`: a loadable down-counter with `load`, `value`, `clear` inputs and an `expire` output (high when the count = 1).

## Test plan
- Reset, then ROM = {MOV,0x00},{SETB,0x05},{MAC,0x00}, `PROG_LEN`=3, `start` pulse → `instr_valid` in cycles 3, 5, 7 carrying MOV/SETB/MAC; `done` in cycle 8; `busy` low in cycle 9.
- {WAIT,0x04} at address 1 → gap between the WAIT's `instr_valid` and the next `instr_valid` = 6 cycles; `imem_en` stays low for 4 cycles.
- {WAIT,0x00} → issue timing is identical to a MOV.
- `stop` asserted in the WAIT state with 3 cycles remaining → IDLE next cycle, no further `instr_valid`, no `done`, `pc` held.
- `start` and `stop` asserted together in IDLE → stays IDLE, `busy`=0; `start` while busy → no restart, `pc` unaffected.
- `SEQ_LOOP_EN`, `PROG_LEN`=2 → the `pc` sequence 0, 1, 0, 1 repeats; `done` pulses at each wrap; `busy` stays high until `stop`.
